// File: rtl/sm3_pkg.sv
// Shared SM3 definitions: word type, expansion FSM states, round count, IV and rotate amounts.
package sm3_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_HOLD,
        ST_RUN
    } state_e;

    localparam int NUM_ROUNDS = 64;
    localparam int IDX_W      = 6;

    localparam int ROT_7  = 7;
    localparam int ROT_15 = 15;
    localparam int ROT_23 = 23;

    // Chaining-value IV, consumed by the compression stage.
    localparam word_t SM3_IV [8] = '{
        32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
        32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e
    };

    function automatic word_t rol(input word_t x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/sm3_p1.sv
// Purely combinational SM3 P1 permutation: P1(x) = x ^ (x <<< 15) ^ (x <<< 23).
module sm3_p1
    import sm3_pkg::*;
(
    input  word_t x_in,
    output word_t p1_out
);

    assign p1_out = x_in ^ rol(x_in, ROT_15) ^ rol(x_in, ROT_23);

endmodule

// File: rtl/sm3_msg_expansion.sv
// SM3 message expansion: accepts one 512-bit block, emits W_j / W'_j per round from a 16-word window.
// Optional macro SM3_EXP_BLOCK_CNT_EN adds a wrapping completed-block counter output.
module sm3_msg_expansion
    import sm3_pkg::*;
#(
    parameter int NUM_ROUNDS = 64,
    parameter int WORD_W     = 32
) (
    input  logic                  clk_in,
    input  logic                  reset_n_in,
    input  logic                  msg_valid_in,
    output logic                  msg_ready_out,
    input  logic [16*WORD_W-1:0]  block_in,
    input  logic                  is_1st_msg_block_in,
    output logic                  start_out,
    output logic                  is_1st_msg_block_out,
    output logic [IDX_W-1:0]      index_j_out,
    output logic [WORD_W-1:0]     word_expanded_out,
    output logic [WORD_W-1:0]     word_expanded_p_out,
    output logic                  block_done_out
`ifdef SM3_EXP_BLOCK_CNT_EN
    ,
    output logic [31:0]           blocks_done_cnt_out
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_ROUNDS - 1);
    localparam logic [IDX_W-1:0] PRE_LAST_IDX = IDX_W'(NUM_ROUNDS - 2);

    state_e           state_q, state_d;
    word_t            win_q [16];
    word_t            win_d [16];
    word_t            blk_words [16];
    logic [IDX_W-1:0] index_q, index_d;
    logic             ready_q, ready_d;
    logic             start_q, start_d;
    logic             first_q, first_d;
    logic             done_q, done_d;
    logic             accept;
    word_t            p1_in, p1_res, new_word;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_blk_words
            assign blk_words[gi] = block_in[WORD_W*(16-gi)-1 -: WORD_W];
        end
    endgenerate

    // W_{j+16} from the current window, where win_q[0] holds W_j.
    assign p1_in    = win_q[0] ^ win_q[7] ^ rol(win_q[13], ROT_15);
    sm3_p1 u_p1 (
        .x_in   (p1_in),
        .p1_out (p1_res)
    );
    assign new_word = p1_res ^ rol(win_q[3], ROT_7) ^ win_q[10];

    assign accept = msg_valid_in && ready_q;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        index_d = index_q;
        start_d = 1'b0;
        first_d = first_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                index_d = '0;
                if (accept) begin
                    win_d   = blk_words;
                    first_d = is_1st_msg_block_in;
                    start_d = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_HOLD;
            ST_HOLD:  state_d = ST_RUN;
            ST_RUN: begin
                for (int i = 0; i < 15; i++) begin
                    win_d[i] = win_q[i+1];
                end
                win_d[15] = new_word;
                done_d    = (index_q == PRE_LAST_IDX);
                if (index_q == LAST_IDX) begin
                    index_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    index_d = index_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= ST_IDLE;
            win_q   <= '{default: '0};
            index_q <= '0;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            index_q <= index_d;
            ready_q <= ready_d;
            start_q <= start_d;
            first_q <= first_d;
            done_q  <= done_d;
        end
    end

    assign msg_ready_out        = ready_q;
    assign start_out            = start_q;
    assign is_1st_msg_block_out = first_q;
    assign index_j_out          = index_q;
    assign block_done_out       = done_q;
    assign word_expanded_out    = win_q[0];
    assign word_expanded_p_out  = win_q[0] ^ win_q[4];

`ifdef SM3_EXP_BLOCK_CNT_EN
    logic [31:0] blocks_done_cnt_q, blocks_done_cnt_d;

    always_comb begin
        blocks_done_cnt_d = blocks_done_cnt_q;
        if (done_q) begin
            blocks_done_cnt_d = blocks_done_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            blocks_done_cnt_q <= '0;
        end else begin
            blocks_done_cnt_q <= blocks_done_cnt_d;
        end
    end

    assign blocks_done_cnt_out = blocks_done_cnt_q;
`endif

endmodule

// File: tb/tb_sm3_msg_expansion.sv
// Scoreboard bench for sm3_msg_expansion; define SM3_EXP_BLOCK_CNT_EN to also cover the block counter.
module tb_sm3_msg_expansion;

    typedef struct {
        logic        start;
        logic        done;
        logic [5:0]  idx;
        logic [31:0] w;
        logic [31:0] wp;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         msg_valid = 1'b0;
    logic         msg_ready;
    logic [511:0] block = '0;
    logic         first_in = 1'b0;
    logic         start;
    logic         first_out;
    logic [5:0]   index_j;
    logic [31:0]  w_out;
    logic [31:0]  wp_out;
    logic         done;
`ifdef SM3_EXP_BLOCK_CNT_EN
    logic [31:0]  cnt_out;
    logic [31:0]  exp_cnt = '0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    exp_t        sb_q [$];
    logic [31:0] model_w [68];
    logic [511:0] abc_blk;
    logic [511:0] blk2;
    logic [511:0] blk3;

    always #5 clk = ~clk;

    sm3_msg_expansion dut (
        .clk_in               (clk),
        .reset_n_in           (reset_n),
        .msg_valid_in         (msg_valid),
        .msg_ready_out        (msg_ready),
        .block_in             (block),
        .is_1st_msg_block_in  (first_in),
        .start_out            (start),
        .is_1st_msg_block_out (first_out),
        .index_j_out          (index_j),
        .word_expanded_out    (w_out),
        .word_expanded_p_out  (wp_out),
        .block_done_out       (done)
`ifdef SM3_EXP_BLOCK_CNT_EN
        ,
        .blocks_done_cnt_out  (cnt_out)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] m_p1(input logic [31:0] x);
        return x ^ m_rol(x, 15) ^ m_rol(x, 23);
    endfunction

    task automatic model_expand(input logic [511:0] blk);
        for (int j = 0; j < 16; j++) begin
            model_w[j] = blk[511 - 32*j -: 32];
        end
        for (int j = 16; j < 68; j++) begin
            model_w[j] = m_p1(model_w[j-16] ^ model_w[j-9] ^ m_rol(model_w[j-3], 15))
                         ^ m_rol(model_w[j-13], 7) ^ model_w[j-6];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) begin
            b[32*i +: 32] = $urandom;
        end
        return b;
    endfunction

    // Called at cycle A (just after a rising edge). mode: 0 drop valid, 1 hold valid with
    // nxt/nxt_flag, 2 pulse valid once mid-run. abort_k >= 0 resets at that run cycle.
    task automatic send_block(input logic [511:0] blk, input logic flag, input int mode,
                              input logic [511:0] nxt, input logic nxt_flag,
                              input int abort_k, input bit is_abc);
        exp_t e;
        msg_valid = 1'b1;
        block     = blk;
        first_in  = flag;
        check_eq("ready_at_accept", msg_ready, 1'b1);
        model_expand(blk);
        for (int k = 0; k < 66; k++) begin
            e.start = (k == 0);
            e.done  = (k == 65);
            e.idx   = (k < 2) ? 6'd0 : 6'(k - 2);
            e.w     = model_w[e.idx];
            e.wp    = model_w[e.idx] ^ model_w[e.idx + 4];
            sb_q.push_back(e);
        end
        tick();
        if (mode == 1) begin
            block    = nxt;
            first_in = nxt_flag;
        end else begin
            msg_valid = 1'b0;
            block     = rand_block();
        end
        for (int k = 0; k < 66; k++) begin
            if (k == abort_k) begin
                reset_n = 1'b0;
                #1;
                sb_q.delete();
                check_eq("rst_start", start, 1'b0);
                check_eq("rst_done", done, 1'b0);
                check_eq("rst_index", index_j, 6'd0);
                check_eq("rst_w", w_out, 32'h0);
                check_eq("rst_wp", wp_out, 32'h0);
                check_eq("rst_first", first_out, 1'b0);
                check_eq("rst_ready", msg_ready, 1'b0);
`ifdef SM3_EXP_BLOCK_CNT_EN
                exp_cnt = '0;
                check_eq("rst_cnt", cnt_out, 32'h0);
`endif
                @(negedge clk);
                reset_n = 1'b1;
                for (int c = 0; c < 40; c++) begin
                    tick();
                    check_eq("abort_no_done", done, 1'b0);
                    check_eq("abort_no_start", start, 1'b0);
                end
                check_eq("abort_ready", msg_ready, 1'b1);
                return;
            end
            e = sb_q.pop_front();
            if (mode == 2 && k == 20) begin
                msg_valid = 1'b1;
                first_in  = ~flag;
                block     = rand_block();
            end else if (mode == 2 && k == 21) begin
                msg_valid = 1'b0;
            end
            check_eq($sformatf("start_k%0d", k), start, e.start);
            check_eq($sformatf("done_k%0d", k), done, e.done);
            check_eq($sformatf("index_k%0d", k), index_j, e.idx);
            check_eq($sformatf("w_k%0d", k), w_out, e.w);
            check_eq($sformatf("wp_k%0d", k), wp_out, e.wp);
            check_eq($sformatf("ready_k%0d", k), msg_ready, 1'b0);
            check_eq($sformatf("first_k%0d", k), first_out, flag);
            if (is_abc && k >= 2 && e.idx == 6'd12) begin
                check_eq("abc_w12", w_out, 32'h00000000);
                check_eq("abc_wp12", wp_out, 32'h9092e200);
            end
            if (is_abc && k >= 2 && e.idx == 6'd16) begin
                check_eq("abc_w16", w_out, 32'h9092e200);
            end
            if (is_abc && k < 2) begin
                check_eq("abc_w0", w_out, 32'h61626380);
                check_eq("abc_wp0", wp_out, 32'h61626380);
            end
            tick();
        end
`ifdef SM3_EXP_BLOCK_CNT_EN
        exp_cnt = exp_cnt + 32'd1;
        check_eq("blocks_done_cnt", cnt_out, exp_cnt);
`endif
        check_eq("post_ready", msg_ready, 1'b1);
        check_eq("post_start", start, 1'b0);
        check_eq("post_done", done, 1'b0);
        check_eq("post_index", index_j, 6'd0);
        check_eq("post_first", first_out, flag);
        check_eq("sb_empty", sb_q.size(), 0);
    endtask

    initial begin
        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0]    = 32'h00000018;
        blk2 = rand_block();
        blk3 = rand_block();

        #1;
        check_eq("reset_start", start, 1'b0);
        check_eq("reset_done", done, 1'b0);
        check_eq("reset_index", index_j, 6'd0);
        check_eq("reset_w", w_out, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        check_eq("idle_ready", msg_ready, 1'b1);
        check_eq("idle_start", start, 1'b0);
        check_eq("idle_done", done, 1'b0);
        check_eq("idle_index", index_j, 6'd0);

        // abc with valid held so the second block is accepted at A+67
        send_block(abc_blk, 1'b1, 1, blk2, 1'b0, -1, 1'b1);
        send_block(blk2, 1'b0, 2, '0, 1'b0, -1, 1'b0);
        tick();
        check_eq("gap_no_start", start, 1'b0);

        // reset while index 30 is presented (run cycle k = 32)
        send_block(abc_blk, 1'b1, 0, '0, 1'b0, 32, 1'b1);
        send_block(abc_blk, 1'b1, 0, '0, 1'b0, -1, 1'b1);
        send_block(blk3, 1'b0, 0, '0, 1'b0, -1, 1'b0);
        send_block(rand_block(), 1'b1, 0, '0, 1'b0, -1, 1'b0);
`ifdef SM3_EXP_BLOCK_CNT_EN
        check_eq("cnt_three", cnt_out, 32'd3);
        @(negedge clk);
        force dut.blocks_done_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.blocks_done_cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        send_block(rand_block(), 1'b0, 0, '0, 1'b0, -1, 1'b0);
        check_eq("cnt_wrap", cnt_out, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sm3_msg_expansion.md
Name: sm3_msg_expansion

Overview:
- Upstream feeder for the SM3 compression stage.
- Accepts one 512-bit padded message block over a valid/ready handshake, then emits the SM3 expanded words W_j and W'_j one round per cycle, with the round index.
- Issues the start pulse that launches the compression function.
- Uses a 16-word sliding window; it does not store all 68 words.

Parameters:
- NUM_ROUNDS, 64, number of rounds emitted per block; fixed at 64 for SM3, and the index width is 6.
- WORD_W, 32, word width; fixed at 32.

Ports:
- clk_in  input  1  clock.
- reset_n_in  input  1  reset, asynchronous, active-low.
- msg_valid_in  input  1  block_in holds a valid block.
- msg_ready_out  output  1  block can be accepted this cycle.
- block_in  input  512  padded block; [511:480] is W0, [31:0] is W15.
- is_1st_msg_block_in  input  1  block is first of the message; sampled on accept.
- start_out  output  1  one-cycle start pulse to the compression stage.
- is_1st_msg_block_out  output  1  registered copy of the sampled flag, held until next accept.
- index_j_out  output  6  current round index j.
- word_expanded_out  output  32  W_j.
- word_expanded_p_out  output  32  W'_j = W_j ^ W_{j+4}.
- block_done_out  output  1  one-cycle pulse when round 63 is presented.

Behaviour:
- Clock and reset: single clock clk_in; reset_n_in is asynchronous, active-low. All state and outputs clear immediately on assertion: outputs 0, FSM IDLE, window all zero.
- FSM states: IDLE, START, HOLD, RUN.
- IDLE:
  - msg_ready_out=1.
  - Accept at cycle A when msg_valid_in && msg_ready_out: load window w[0..15] from block_in, capture the flag, go to START.
- START (cycle T=A+1):
  - start_out=1, index_j_out=0.
  - Go to HOLD.
- HOLD (T+1):
  - index_j_out=0, W_0/W'_0 presented, window not shifted.
  - Go to RUN.
- RUN (T+2 .. T+65):
  - Round r is presented at cycle T+2+r, so index 0 appears at T+1 and T+2.
  - Each cycle: shift window left by one, w[15] <= W_{j+16}, and index increments.
  - At index 63, block_done_out=1; next state IDLE, with msg_ready_out=1 from T+66.
- msg_ready_out=0 in START, HOLD and RUN. msg_valid_in is ignored there, and block_in need not be held after accept.
- Outputs word_expanded_out=w[0] and word_expanded_p_out=w[0]^w[4] are driven combinationally from the registered window.
  - Values are valid whenever FSM is not IDLE, and are don't-care in IDLE.
- New word: W_{j+16} = P1(w[0]^w[7]^ROL(w[13],15)) ^ ROL(w[3],7) ^ w[10].
  - P1(x) = x^ROL(x,15)^ROL(x,23).
  - All operations are 32-bit, with no carries.
- Words past W_67 are never required. Shifting during rounds 52..63 still computes words; they are unused and harmless.
- Reset asserted mid-block aborts it: no block_done_out, outputs cleared, and the next accept starts a fresh block.
- index_j_out never exceeds 63 and does not wrap within a block.

Optional Feature:
- Macro SM3_EXP_BLOCK_CNT_EN.
- Defined:
  - Adds output blocks_done_cnt_out [31:0].
  - Reset value 0; increments on each block_done_out; wraps from FFFFFFFF to 0.
- Undefined: port and counter are absent, and all other behaviour is identical.

Decomposition:
- Shared package sm3_pkg:
  - word typedef (32-bit);
  - FSM state enum;
  - NUM_ROUNDS;
  - IV constants 7380166f..b0fb0e4e, for shared use with the compression stage;
  - rotate constants 7, 15, 23.
- One sub-module, sm3_p1: purely combinational P1 permutation, reusable by testbenches.

Test Plan:
- Reset, then idle: msg_ready_out=1; start_out, block_done_out and index_j_out all 0.
- Accept the "abc" block (61626380, then 14 zero words, then 00000018) with is_1st_msg_block_in=1:
  - start_out at A+1;
  - index 0 with W=61626380, W'=61626380 at A+2 and A+3;
  - at index 12: W=00000000, W'=9092e200;
  - at index 16: W=9092e200;
  - block_done_out at A+66;
  - is_1st_msg_block_out=1.
- Back-to-back blocks:
  - msg_valid_in held high: second accept occurs at A+67, no earlier;
  - is_1st_msg_block_out follows the second flag (0).
- Valid pulsed during RUN: ignored, with no state change and no second start_out.
- Async reset asserted at index 30: outputs go to 0 immediately; no block_done_out; a fresh "abc" accept reproduces the expected words.
- With SM3_EXP_BLOCK_CNT_EN:
  - three blocks gives blocks_done_cnt_out=3;
  - a forced preload of FFFFFFFF plus one block gives 0.
